// File: rtl/vram_rect_writer_if.sv
// Command channel and VRAM CPU write port bundled for the rectangle writer.
// The master side issues commands and observes writes; the slave side is the engine.
interface vram_rect_writer_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [5:0]        cmd_x0;
  logic [4:0]        cmd_y0;
  logic [5:0]        cmd_w;
  logic [4:0]        cmd_h;
  logic [DATA_W-1:0] cmd_color;
  logic              cmd_pattern;
  logic              cmd_sync;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, cmd_pattern, cmd_sync,
    input  cmd_ready, cpu_we, cpu_addr, cpu_data
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, cmd_pattern, cmd_sync,
    output cmd_ready, cpu_we, cpu_addr, cpu_data
  );
endinterface

// File: rtl/vram_rect_writer.sv
// Rectangle fill engine for the 40x30 tile VRAM: one clipped cell write per clock,
// optionally deferred to the next vsync_ready rising edge.
module vram_rect_writer #(
  parameter int GRID_W = 40,
  parameter int GRID_H = 30,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 2
) (
  input  logic                sys_clock,
  input  logic                reset_n,
  vram_rect_writer_if.slave   bus,
  input  logic                vsync_ready,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_VS = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [5:0]        GridW6  = 6'(GRID_W);
  localparam logic [6:0]        GridW7  = 7'(GRID_W);
  localparam logic [4:0]        GridH5  = 5'(GRID_H);
  localparam logic [5:0]        GridH6  = 6'(GRID_H);
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(GRID_W);

  logic [1:0]        state_q,   state_d;
  logic [5:0]        x0_q,      x0_d;
  logic [5:0]        x_q,       x_d;
  logic [4:0]        y_q,       y_d;
  logic [5:0]        xEnd_q,    xEnd_d;
  logic [4:0]        yEnd_q,    yEnd_d;
  logic [ADDR_W-1:0] rowBase_q, rowBase_d;
  logic              pattern_q, pattern_d;
  logic [DATA_W-1:0] color_q,   color_d;
  logic              last_q,    last_d;
  logic              vsPrev_q;
  logic              cpuWe_q,   cpuWe_d;
  logic [ADDR_W-1:0] cpuAddr_q, cpuAddr_d;
  logic [DATA_W-1:0] cpuData_q, cpuData_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;

  logic              accept, cmdOk, loadCmd, issue, lastCol, lastRow;
  logic [6:0]        sumX;
  logic [5:0]        sumY;
  logic [5:0]        clipXEnd, curX, curX0, curXEnd;
  logic [4:0]        clipYEnd, curY, curYEnd;
  logic [ADDR_W-1:0] curBase, issueAddr;
  logic              curPattern;
  logic [DATA_W-1:0] curColor;

  function automatic logic [DATA_W-1:0] patData(input logic [1:0] a);
    case (a)
      2'd0:    patData = DATA_W'(2'b01);
      2'd1:    patData = DATA_W'(2'b00);
      2'd2:    patData = DATA_W'(2'b10);
      default: patData = DATA_W'(2'b11);
    endcase
  endfunction

  assign accept   = bus.cmd_valid && (state_q == IDLE);
  assign cmdOk    = (bus.cmd_w != 6'd0) && (bus.cmd_h != 5'd0) &&
                    (bus.cmd_x0 < GridW6) && (bus.cmd_y0 < GridH5);
  assign loadCmd  = accept && cmdOk;
  assign sumX     = {1'b0, bus.cmd_x0} + {1'b0, bus.cmd_w};
  assign sumY     = {1'b0, bus.cmd_y0} + {1'b0, bus.cmd_h};
  assign clipXEnd = (sumX > GridW7) ? GridW6 : sumX[5:0];
  assign clipYEnd = (sumY > GridH6) ? GridH5 : sumY[4:0];

  // The cell being issued comes straight from the command on an unsynced accept,
  // so the first write lands one cycle after acceptance.
  assign curX       = loadCmd ? bus.cmd_x0      : x_q;
  assign curX0      = loadCmd ? bus.cmd_x0      : x0_q;
  assign curY       = loadCmd ? bus.cmd_y0      : y_q;
  assign curXEnd    = loadCmd ? clipXEnd        : xEnd_q;
  assign curYEnd    = loadCmd ? clipYEnd        : yEnd_q;
  assign curBase    = loadCmd ? ADDR_W'(bus.cmd_y0) * RowStep : rowBase_q;
  assign curPattern = loadCmd ? bus.cmd_pattern : pattern_q;
  assign curColor   = loadCmd ? bus.cmd_color   : color_q;
  assign issueAddr  = curBase + ADDR_W'(curX);
  assign lastCol    = (curX == curXEnd - 6'd1);
  assign lastRow    = (curY == curYEnd - 5'd1);

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    x_d       = x_q;
    y_d       = y_q;
    xEnd_d    = xEnd_q;
    yEnd_d    = yEnd_q;
    rowBase_d = rowBase_q;
    pattern_d = pattern_q;
    color_d   = color_q;
    last_d    = last_q;
    cpuWe_d   = 1'b0;
    cpuAddr_d = cpuAddr_q;
    cpuData_d = cpuData_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!cmdOk) begin
            err_d = 1'b1;
          end else begin
            x0_d      = bus.cmd_x0;
            xEnd_d    = clipXEnd;
            yEnd_d    = clipYEnd;
            pattern_d = bus.cmd_pattern;
            color_d   = bus.cmd_color;
            if (bus.cmd_sync) begin
              state_d   = WAIT_VS;
              x_d       = bus.cmd_x0;
              y_d       = bus.cmd_y0;
              rowBase_d = curBase;
            end else begin
              state_d = WRITE;
              issue   = 1'b1;
            end
          end
        end
      end
      WAIT_VS: begin
        if (vsync_ready && !vsPrev_q) begin
          state_d = WRITE;
          issue   = 1'b1;
        end
      end
      WRITE: begin
        if (last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          issue = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      cpuWe_d   = 1'b1;
      cpuAddr_d = issueAddr;
      cpuData_d = curPattern ? patData(issueAddr[1:0]) : curColor;
      last_d    = lastCol && lastRow;
      if (lastCol) begin
        x_d       = curX0;
        y_d       = curY + 5'd1;
        rowBase_d = curBase + RowStep;
      end else begin
        x_d       = curX + 6'd1;
        y_d       = curY;
        rowBase_d = curBase;
      end
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      xEnd_q    <= '0;
      yEnd_q    <= '0;
      rowBase_q <= '0;
      pattern_q <= 1'b0;
      color_q   <= '0;
      last_q    <= 1'b0;
      vsPrev_q  <= 1'b0;
      cpuWe_q   <= 1'b0;
      cpuAddr_q <= '0;
      cpuData_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      x_q       <= x_d;
      y_q       <= y_d;
      xEnd_q    <= xEnd_d;
      yEnd_q    <= yEnd_d;
      rowBase_q <= rowBase_d;
      pattern_q <= pattern_d;
      color_q   <= color_d;
      last_q    <= last_d;
      vsPrev_q  <= vsync_ready;
      cpuWe_q   <= cpuWe_d;
      cpuAddr_q <= cpuAddr_d;
      cpuData_q <= cpuData_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.cpu_we    = cpuWe_q;
  assign bus.cpu_addr  = cpuAddr_q;
  assign bus.cpu_data  = cpuData_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_vram_rect_writer.sv
// Directed bench for vram_rect_writer: expected writes are queued when a command
// is driven and popped by a monitor as cpu_we cycles appear.
module tb_vram_rect_writer;
  localparam int GRID_W = 40;
  localparam int GRID_H = 30;

  logic sys_clock = 1'b0;
  logic reset_n;
  logic vsync_ready;
  logic busy, done, err;

  vram_rect_writer_if #(.ADDR_W(11), .DATA_W(2)) bus ();

  vram_rect_writer #(.GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(11), .DATA_W(2)) dut (
    .sys_clock   (sys_clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .vsync_ready (vsync_ready),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 sys_clock = ~sys_clock;

  typedef struct packed {
    logic [10:0] addr;
    logic [1:0]  data;
  } wrExp_t;

  wrExp_t expQ[$];
  int total = 0, bad = 0, cyc = 0, writes = 0, doneCount = 0, errCount = 0;
  int firstWriteCyc = -1, lastWriteCyc = -1;

  always @(posedge sys_clock) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] patModel(input int a);
    case (a % 4)
      0:       patModel = 2'b01;
      1:       patModel = 2'b00;
      2:       patModel = 2'b10;
      default: patModel = 2'b11;
    endcase
  endfunction

  // Monitor: every write must match the head of the expected queue.
  always @(negedge sys_clock) begin
    wrExp_t e;
    if (reset_n && bus.cpu_we === 1'b1) begin
      writes++;
      if (firstWriteCyc < 0) firstWriteCyc = cyc;
      lastWriteCyc = cyc;
      if (expQ.size() == 0) begin
        checkOutput("spurious write", 32'(bus.cpu_we), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("write addr", 32'(bus.cpu_addr), 32'(e.addr));
        checkOutput("write data", 32'(bus.cpu_data), 32'(e.data));
      end
    end
    if (reset_n && done === 1'b1) doneCount++;
    if (reset_n && err === 1'b1) errCount++;
  end

  task automatic applyStimulus(input int x0, input int y0, input int w, input int h,
                               input logic [1:0] color, input bit pattern, input bit sync);
    wrExp_t e;
    int a;
    @(negedge sys_clock);
    bus.cmd_x0      = 6'(x0);
    bus.cmd_y0      = 5'(y0);
    bus.cmd_w       = 6'(w);
    bus.cmd_h       = 5'(h);
    bus.cmd_color   = color;
    bus.cmd_pattern = pattern;
    bus.cmd_sync    = sync;
    if (w != 0 && h != 0 && x0 < GRID_W && y0 < GRID_H) begin
      for (int y = y0; y < y0 + h && y < GRID_H; y++) begin
        for (int x = x0; x < x0 + w && x < GRID_W; x++) begin
          a = y * GRID_W + x;
          e.addr = 11'(a);
          e.data = pattern ? patModel(a) : color;
          expQ.push_back(e);
        end
      end
    end
    firstWriteCyc = -1;
    bus.cmd_valid = 1'b1;
    @(posedge sys_clock);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int bound, input string tag);
    int n = 0;
    do begin
      @(negedge sys_clock);
      n++;
    end while (done !== 1'b1 && n < bound);
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int base, dBase, eBase, n;
    reset_n         = 1'b0;
    vsync_ready     = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_x0      = '0;
    bus.cmd_y0      = '0;
    bus.cmd_w       = '0;
    bus.cmd_h       = '0;
    bus.cmd_color   = '0;
    bus.cmd_pattern = 1'b0;
    bus.cmd_sync    = 1'b0;
    #1;
    checkOutput("reset cpu_we", 32'(bus.cpu_we), 32'd0);
    checkOutput("reset cpu_addr", 32'(bus.cpu_addr), 32'd0);
    checkOutput("reset cpu_data", 32'(bus.cpu_data), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    repeat (2) @(negedge sys_clock);
    reset_n = 1'b1;
    @(negedge sys_clock);
    checkOutput("post-reset cmd_ready", 32'(bus.cmd_ready), 32'd1);

    $display("[TB] full-screen pattern fill");
    base = writes; dBase = doneCount;
    applyStimulus(0, 0, 40, 30, 2'b00, 1'b1, 1'b0);
    @(negedge sys_clock);
    checkOutput("t1 first write latency", 32'(bus.cpu_we), 32'd1);
    checkOutput("t1 busy", 32'(busy), 32'd1);
    checkOutput("t1 cmd_ready low", 32'(bus.cmd_ready), 32'd0);
    waitDone(1300, "t1 done seen");
    checkOutput("t1 we low at done", 32'(bus.cpu_we), 32'd0);
    checkOutput("t1 write count", 32'(writes - base), 32'd1200);
    checkOutput("t1 consecutive writes", 32'(lastWriteCyc - firstWriteCyc + 1), 32'd1200);
    checkOutput("t1 done after last write", 32'(cyc - lastWriteCyc), 32'd1);
    checkOutput("t1 queue drained", 32'(expQ.size()), 32'd0);
    @(negedge sys_clock);
    checkOutput("t1 idle cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("t1 idle busy", 32'(busy), 32'd0);
    checkOutput("t1 done one cycle", 32'(done), 32'd0);
    checkOutput("t1 done count", 32'(doneCount - dBase), 32'd1);

    $display("[TB] clipped corner fill");
    base = writes; dBase = doneCount;
    applyStimulus(38, 28, 5, 4, 2'b10, 1'b0, 1'b0);
    waitDone(50, "t2 done seen");
    checkOutput("t2 write count", 32'(writes - base), 32'd4);
    checkOutput("t2 queue drained", 32'(expQ.size()), 32'd0);
    @(negedge sys_clock);
    checkOutput("t2 done count", 32'(doneCount - dBase), 32'd1);

    $display("[TB] rejected commands");
    base = writes; eBase = errCount;
    applyStimulus(5, 5, 0, 3, 2'b11, 1'b0, 1'b0);
    @(negedge sys_clock);
    checkOutput("t3a err pulse", 32'(err), 32'd1);
    checkOutput("t3a busy", 32'(busy), 32'd0);
    checkOutput("t3a cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge sys_clock);
    checkOutput("t3a err one cycle", 32'(err), 32'd0);
    applyStimulus(40, 0, 2, 2, 2'b11, 1'b0, 1'b0);
    @(negedge sys_clock);
    checkOutput("t3b err pulse", 32'(err), 32'd1);
    checkOutput("t3b cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge sys_clock);
    checkOutput("t3b err one cycle", 32'(err), 32'd0);
    checkOutput("t3 err count", 32'(errCount - eBase), 32'd2);
    checkOutput("t3 no writes", 32'(writes - base), 32'd0);

    $display("[TB] frame-synchronised fill");
    base = writes;
    vsync_ready = 1'b1;
    applyStimulus(5, 3, 2, 2, 2'b01, 1'b0, 1'b1);
    repeat (5) @(negedge sys_clock);
    checkOutput("t4 held level no writes", 32'(writes - base), 32'd0);
    checkOutput("t4 busy waiting", 32'(busy), 32'd1);
    vsync_ready = 1'b0;
    repeat (3) @(negedge sys_clock);
    checkOutput("t4 low no writes", 32'(writes - base), 32'd0);
    vsync_ready = 1'b1;
    @(negedge sys_clock);
    checkOutput("t4 write after edge", 32'(bus.cpu_we), 32'd1);
    checkOutput("t4 first addr", 32'(bus.cpu_addr), 32'd125);
    waitDone(20, "t4 done seen");
    checkOutput("t4 write count", 32'(writes - base), 32'd4);
    vsync_ready = 1'b0;

    $display("[TB] command during fill is ignored");
    base = writes;
    applyStimulus(0, 0, 10, 10, 2'b01, 1'b0, 1'b0);
    @(negedge sys_clock);
    bus.cmd_valid = 1'b1;
    bus.cmd_x0    = 6'd20;
    bus.cmd_y0    = 5'd20;
    bus.cmd_w     = 6'd3;
    bus.cmd_h     = 5'd3;
    bus.cmd_color = 2'b11;
    checkOutput("t5 cmd_ready low", 32'(bus.cmd_ready), 32'd0);
    @(negedge sys_clock);
    checkOutput("t5 cmd_ready still low", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b0;
    waitDone(200, "t5 done seen");
    checkOutput("t5 write count", 32'(writes - base), 32'd100);
    checkOutput("t5 queue drained", 32'(expQ.size()), 32'd0);

    $display("[TB] reset during fill");
    base = writes;
    applyStimulus(0, 0, 40, 30, 2'b11, 1'b0, 1'b0);
    n = 0;
    while (writes - base < 50 && n < 200) begin
      @(negedge sys_clock);
      n++;
    end
    checkOutput("t6 reached 50 writes", 32'(writes - base >= 50), 32'd1);
    @(posedge sys_clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6 async we drop", 32'(bus.cpu_we), 32'd0);
    checkOutput("t6 async busy drop", 32'(busy), 32'd0);
    expQ.delete();
    repeat (2) @(negedge sys_clock);
    reset_n = 1'b1;
    base = writes;
    repeat (20) @(negedge sys_clock);
    checkOutput("t6 no writes after reset", 32'(writes - base), 32'd0);
    checkOutput("t6 cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("t6 busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vram_rect_writer.md
Name: vram_rect_writer

Overview:
Command-driven VRAM write engine. It is the initiator on the vga_controller CPU write port (cpu_we/cpu_addr/cpu_data) and the consumer of its vsync_ready frame marker. It accepts a rectangle command on the 40x30 tile grid and writes every covered cell at one write per clock. Writes can optionally be held back until the start of the next frame, so a frame never shows a partly drawn rectangle.

Parameters:
GRID_W, 40, tiles per row (640/16)
GRID_H, 30, tile rows (480/16)
ADDR_W, 11, VRAM address width (must cover GRID_W*GRID_H = 1200)
DATA_W, 2, colour code width per tile

Ports:
sys_clock  in  1  system clock (100 MHz); single clock domain
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine idle, able to accept a command
cmd_x0  in  6  left column
cmd_y0  in  5  top row
cmd_w  in  6  width in tiles
cmd_h  in  5  height in tiles
cmd_color  in  DATA_W  fill colour (solid mode)
cmd_pattern  in  1  1 = 4-phase pattern, 0 = solid cmd_color
cmd_sync  in  1  1 = hold writes until next vsync_ready rising edge
vsync_ready  in  1  frame-complete marker from vga_controller
cpu_we  out  1  VRAM write strobe
cpu_addr  out  ADDR_W  VRAM write address
cpu_data  out  DATA_W  VRAM write data
busy  out  1  command in progress
done  out  1  one-cycle pulse when the last write has been issued
err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (async, reset_n=0):
  - FSM goes to IDLE.
  - cpu_we, cpu_addr, cpu_data, busy, done and err are all 0.
  - cmd_ready is 1 after reset is released.
  - Reset mid-command aborts it: cpu_we drops immediately and no further writes occur.
- Accept: a command is taken on the cycle where cmd_valid && cmd_ready. The engine registers all cmd_* fields and cmd_ready goes to 0 on the next cycle. cmd_valid is ignored while busy.
- Validation, done at accept:
  - Reject if cmd_w==0, cmd_h==0, cmd_x0>=GRID_W or cmd_y0>=GRID_H.
  - On reject: err pulses on the next cycle, there are no writes, the FSM stays IDLE and cmd_ready remains 1.
- Clipping: x_end = min(x0+w, GRID_W) and y_end = min(y0+h, GRID_H). Sums use 7-bit and 6-bit intermediates so they cannot overflow. Cells outside the grid are never written.
- FSM: IDLE -> (cmd_sync ? WAIT_VS : WRITE) -> WRITE -> DONE -> IDLE.
  - WAIT_VS: detect a vsync_ready rising edge using an internally registered copy of vsync_ready. On the edge cycle, move to WRITE.
    - A level that is already high at accept does not count as an edge.
  - WRITE: one cell per cycle, in raster order (x increments; at x_end-1, x returns to x0 and y increments).
    - Each WRITE cycle registers cpu_we=1, cpu_addr = y*GRID_W + x, and cpu_data.
    - The address comes from a row base that is incremented by GRID_W per row. No multiplier.
    - After the cell (x_end-1, y_end-1) has been written, move to DONE.
  - DONE: cpu_we=0 and done=1 for exactly one cycle. The next cycle is IDLE with cmd_ready=1 and busy=0.
- busy is 1 from the cycle after accept through the DONE cycle.
- Latency with cmd_sync=0: the first cpu_we is asserted 1 cycle after the accept cycle. The number of write cycles equals the clipped area.
- Latency with cmd_sync=1: the first cpu_we is asserted 1 cycle after the detected vsync_ready edge.
- Data:
  - Solid mode: cpu_data = cmd_color.
  - Pattern mode: cpu_data depends on cpu_addr[1:0]: 0 -> 2'b01, 1 -> 2'b00, 2 -> 2'b10, 3 -> 2'b11.
- cpu_addr and cpu_data hold their last values when cpu_we=0. Only cpu_we qualifies a write.

Test Plan:
1. Full screen: x0=0, y0=0, w=40, h=30, pattern=1, sync=0 -> exactly 1200 consecutive cpu_we cycles with addr 0..1199, data following the addr%4 map (01,00,10,11). done pulses on the cycle after addr 1199. The vga_controller frame dump shows 4-colour columns.
2. Clipping: x0=38, y0=28, w=5, h=4, solid colour 2'b10 -> exactly 4 writes to addrs 1158, 1159, 1198, 1199, all with data 2'b10. done pulses once.
3. Reject: w=0 (and separately x0=40) -> err pulses for 1 cycle, cpu_we never rises, cmd_ready stays 1 and busy stays 0.
4. Frame sync: sync=1 while vsync_ready is held high at accept -> no writes until vsync_ready falls and rises again. The first write to addr y0*40+x0 occurs 1 cycle after that rising edge.
5. Backpressure: pulse cmd_valid with different fields during a 10x10 fill -> cmd_ready=0, the second command is ignored, and exactly 100 writes occur.
6. Reset mid-fill: assert reset_n=0 after 50 writes of a full-screen fill -> cpu_we=0 asynchronously. After release: cmd_ready=1, busy=0, and there are no further writes.
